// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two writeback sources, the issue logic and the register-file write port.
// The requester side (ALU, load unit, issue logic) uses the master modport; the arbiter uses slave.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  // Handshake: a transfer happens when valid && ready at a posedge. A requester holds
  // valid/addr/data stable until its transfer. ready is combinational from valid and the pointer.
  logic                   a_valid;
  logic [ADDR_W-1:0]      a_addr;
  logic [DATA_W-1:0]      a_data;
  logic                   a_ready;
  logic                   b_valid;
  logic [ADDR_W-1:0]      b_addr;
  logic [DATA_W-1:0]      b_data;
  logic                   b_ready;
  logic                   rsv_valid;
  logic [ADDR_W-1:0]      rsv_addr;
  logic [(1<<ADDR_W)-1:0] busy;
  logic                   rf_we;
  logic [ADDR_W-1:0]      rf_waddr;
  logic [DATA_W-1:0]      rf_wdata;
  logic [CNT_W-1:0]       conflict_cnt;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, rsv_valid, rsv_addr,
    input  a_ready, b_ready, busy, rf_we, rf_waddr, rf_wdata, conflict_cnt
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, rsv_valid, rsv_addr,
    output a_ready, b_ready, busy, rf_we, rf_waddr, rf_wdata, conflict_cnt
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register file's single write port (ALU vs load unit),
// with a registered one-cycle write pulse and a pending-write scoreboard.
module regfile_wb_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_wb_arbiter_if.slave   bus,
  output logic                  ptr_o
);
  localparam int NREG = 1 << ADDR_W;

  // ptr_q: 0 = A has priority on contention, 1 = B has priority.
  logic              ptr_q, ptr_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              grant_a, grant_b, xfer;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  always_comb begin
    grant_a    = bus.a_valid && (!bus.b_valid || !ptr_q);
    grant_b    = bus.b_valid && (!bus.a_valid ||  ptr_q);
    xfer       = grant_a || grant_b;
    win_addr   = grant_a ? bus.a_addr : bus.b_addr;
    win_data   = grant_a ? bus.a_data : bus.b_data;

    // The granted requester drops to lowest priority.
    ptr_d = ptr_q;
    if (grant_a)      ptr_d = 1'b1;
    else if (grant_b) ptr_d = 1'b0;

    // x0 is hardwired: the transfer is accepted but never reaches the register file.
    rf_we_d    = xfer && (win_addr != '0);
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (rf_we_d) begin
      rf_waddr_d = win_addr;
      rf_wdata_d = win_data;
    end

    // Clear first so a same-edge reservation of the same register wins.
    busy_d = busy_q;
    if (xfer)          busy_d[win_addr]     = 1'b0;
    if (bus.rsv_valid) busy_d[bus.rsv_addr] = 1'b1;
    busy_d[0] = 1'b0;

    cnt_d = cnt_q;
    if (bus.a_valid && bus.b_valid && (cnt_q != '1))
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
      cnt_q      <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.a_ready      = grant_a;
  assign bus.b_ready      = grant_b;
  assign bus.busy         = busy_q;
  assign bus.rf_we        = rf_we_q;
  assign bus.rf_waddr     = rf_waddr_q;
  assign bus.rf_wdata     = rf_wdata_q;
  assign bus.conflict_cnt = cnt_q;
  assign ptr_o            = ptr_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: handshake, round-robin order, write pulse,
// scoreboard, x0 handling, same-destination ordering, async reset and counter saturation.
module tb_regfile_wb_arbiter;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ptr;
  int   checks = 0;
  int   errors = 0;
  logic [DATA_W-1:0] rf_model [32];

  regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .ptr_o (ptr)
  );

  always #5 clk = ~clk;

  // Register-file model: captures on the negedge of a write-enable cycle.
  always @(negedge clk) begin
    if (!rst && bus.rf_we) rf_model[bus.rf_waddr] = bus.rf_wdata;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
    bus.rsv_valid = 1'b0; bus.rsv_addr = '0;
  endtask

  initial begin
    logic [63:0] exp_addr, exp_data;
    int na, nb;
    idle_inputs();
    for (int i = 0; i < 32; i++) rf_model[i] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_rf_we", bus.rf_we, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_cnt", bus.conflict_cnt, 0);
    check("rst_ptr", ptr, 0);
    rst = 1'b0;
    tick();

    // Single A request
    bus.a_valid = 1'b1; bus.a_addr = 5; bus.a_data = 64'hDEAD;
    #1;
    check("a_only_a_ready", bus.a_ready, 1);
    check("a_only_b_ready", bus.b_ready, 0);
    check("a_only_no_pulse_yet", bus.rf_we, 0);
    tick();
    bus.a_valid = 1'b0;
    check("a_only_rf_we", bus.rf_we, 1);
    check("a_only_waddr", bus.rf_waddr, 5);
    check("a_only_wdata", bus.rf_wdata, 64'hDEAD);
    check("a_only_ptr", ptr, 1);
    tick();
    check("a_only_pulse_end", bus.rf_we, 0);
    check("a_only_waddr_hold", bus.rf_waddr, 5);

    // Single B request moves the pointer back to A
    bus.b_valid = 1'b1; bus.b_addr = 9; bus.b_data = 64'h99;
    #1;
    check("b_only_b_ready", bus.b_ready, 1);
    tick();
    bus.b_valid = 1'b0;
    check("b_only_waddr", bus.rf_waddr, 9);
    check("b_only_ptr", ptr, 0);

    // Contention for 4 edges: A,B,A,B
    na = 0; nb = 0;
    bus.a_valid = 1'b1; bus.a_addr = 10;
    bus.b_valid = 1'b1; bus.b_addr = 11;
    for (int i = 0; i < 4; i++) begin
      bus.a_data = 64'hA0 + 64'(na);
      bus.b_data = 64'hB0 + 64'(nb);
      #1;
      check("rr_a_ready", bus.a_ready, (i % 2 == 0) ? 1 : 0);
      check("rr_b_ready", bus.b_ready, (i % 2 == 1) ? 1 : 0);
      check("rr_not_both", bus.a_ready && bus.b_ready, 0);
      exp_addr = (i % 2 == 0) ? 64'd10 : 64'd11;
      exp_data = (i % 2 == 0) ? 64'hA0 + 64'(na) : 64'hB0 + 64'(nb);
      if (i % 2 == 0) na++; else nb++;
      tick();
      check("rr_cnt", bus.conflict_cnt, 64'(i + 1));
      check("rr_rf_we", bus.rf_we, 1);
      check("rr_waddr", bus.rf_waddr, exp_addr);
      check("rr_wdata", bus.rf_wdata, exp_data);
    end
    idle_inputs();
    tick();
    check("rr_cnt_hold", bus.conflict_cnt, 4);
    check("rr_ptr_after", ptr, 0);

    // Scoreboard: reserve then clear
    bus.rsv_valid = 1'b1; bus.rsv_addr = 7;
    #1;
    check("sb_no_bypass", bus.busy[7], 0);
    tick();
    bus.rsv_valid = 1'b0;
    check("sb_set", bus.busy[7], 1);
    bus.a_valid = 1'b1; bus.a_addr = 7; bus.a_data = 64'h77;
    tick();
    bus.a_valid = 1'b0;
    check("sb_clear", bus.busy[7], 0);
    // Same-edge set and clear: set wins
    bus.rsv_valid = 1'b1; bus.rsv_addr = 7;
    bus.a_valid = 1'b1; bus.a_addr = 7; bus.a_data = 64'h78;
    tick();
    idle_inputs();
    check("sb_set_wins", bus.busy[7], 1);
    check("sb_ptr", ptr, 1);

    // Write to x0 from B, reservation of x0
    bus.b_valid = 1'b1; bus.b_addr = 0; bus.b_data = 64'h1;
    bus.rsv_valid = 1'b1; bus.rsv_addr = 0;
    #1;
    check("x0_b_ready", bus.b_ready, 1);
    tick();
    idle_inputs();
    check("x0_no_we", bus.rf_we, 0);
    check("x0_busy0", bus.busy[0], 0);
    check("x0_busy_all", bus.busy, 32'h80);
    check("x0_ptr", ptr, 0);

    // Same destination from both: writes 1 then 2
    bus.a_valid = 1'b1; bus.a_addr = 3; bus.a_data = 64'h1;
    bus.b_valid = 1'b1; bus.b_addr = 3; bus.b_data = 64'h2;
    #1;
    check("same_a_first", bus.a_ready, 1);
    tick();
    bus.a_valid = 1'b0;
    check("same_w1_we", bus.rf_we, 1);
    check("same_w1_data", bus.rf_wdata, 1);
    #1;
    check("same_b_second", bus.b_ready, 1);
    tick();
    bus.b_valid = 1'b0;
    check("same_w2_we", bus.rf_we, 1);
    check("same_w2_addr", bus.rf_waddr, 3);
    check("same_w2_data", bus.rf_wdata, 2);
    tick();
    check("same_rf_read3", rf_model[3], 2);
    check("same_cnt", bus.conflict_cnt, 5);

    // Async reset in the middle of a write pulse
    bus.a_valid = 1'b1; bus.a_addr = 4; bus.a_data = 64'h44;
    bus.rsv_valid = 1'b1; bus.rsv_addr = 12;
    tick();
    idle_inputs();
    check("mid_pulse_we", bus.rf_we, 1);
    #1;
    rst = 1'b1;
    #1;
    check("arst_rf_we", bus.rf_we, 0);
    check("arst_waddr", bus.rf_waddr, 0);
    check("arst_wdata", bus.rf_wdata, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_cnt", bus.conflict_cnt, 0);
    check("arst_ptr", ptr, 0);
    tick();
    rst = 1'b0;
    tick();

    // Contention counter saturates at 2**CNT_W-1
    bus.a_valid = 1'b1; bus.a_addr = 1; bus.a_data = 64'h11;
    bus.b_valid = 1'b1; bus.b_addr = 2; bus.b_data = 64'h22;
    for (int i = 0; i < 14; i++) tick();
    check("sat_below", bus.conflict_cnt, 14);
    for (int i = 0; i < 6; i++) tick();
    check("sat_max", bus.conflict_cnt, 15);
    idle_inputs();
    tick();
    check("sat_hold", bus.conflict_cnt, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
